// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional parity, stop period.
// Timed by a shared 16x oversampling tick; one bit lasts 16 ticks.
module uart_transmitter #(
  parameter int unsigned DATA_BITS      = 10,
  parameter int unsigned STP_BITS_TICKS = 16,
  parameter int unsigned PARITY_EN      = 0,
  parameter int unsigned PARITY_ODD     = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_bd_tick,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned MAX_TICKS     = (STP_BITS_TICKS > TICKS_PER_BIT) ? STP_BITS_TICKS
                                                                           : TICKS_PER_BIT;
  localparam int unsigned CNT_W         = $clog2(MAX_TICKS);
  localparam int unsigned BIT_W         = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic        ODD_BIT       = (PARITY_ODD != 0);
  localparam logic        HAS_PARITY    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_nx;
  logic [CNT_W-1:0]     w_tick_nx;
  logic [BIT_W-1:0]     w_bit_nx;
  logic [DATA_BITS-1:0] w_shift_nx;
  logic                 w_parity_nx;
  logic                 w_tx_nx;
  logic                 w_busy_nx;
  logic                 w_done_nx;
  logic                 w_bit_end;
  logic                 w_stop_end;

  // State, counters, datapath and registered outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_tick_cnt <= w_tick_nx;
      r_bit_cnt  <= w_bit_nx;
      r_shift    <= w_shift_nx;
      r_parity   <= w_parity_nx;
      r_tx       <= w_tx_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
    end
  end

  assign w_bit_end  = i_bd_tick && (r_tick_cnt == CNT_W'(TICKS_PER_BIT - 1));
  assign w_stop_end = i_bd_tick && (r_tick_cnt == CNT_W'(STP_BITS_TICKS - 1));

  // Next-state logic; the tick counter only advances on baud ticks
  always_comb begin
    w_state_nx  = r_state;
    w_tick_nx   = r_tick_cnt;
    w_bit_nx    = r_bit_cnt;
    w_shift_nx  = r_shift;
    w_parity_nx = r_parity;
    w_done_nx   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_tx_start) begin
          w_shift_nx  = i_data;
          w_parity_nx = (^i_data) ^ ODD_BIT;
          w_tick_nx   = '0;
          w_state_nx  = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_tick_nx  = '0;
          w_bit_nx   = '0;
          w_state_nx = S_DATA;
        end else if (i_bd_tick) begin
          w_tick_nx = r_tick_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_tick_nx  = '0;
          w_shift_nx = r_shift >> 1;
          if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            w_bit_nx   = '0;
            w_state_nx = HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            w_bit_nx = r_bit_cnt + BIT_W'(1);
          end
        end else if (i_bd_tick) begin
          w_tick_nx = r_tick_cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_tick_nx  = '0;
          w_state_nx = S_STOP;
        end else if (i_bd_tick) begin
          w_tick_nx = r_tick_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_stop_end) begin
          w_tick_nx  = '0;
          w_done_nx  = 1'b1;
          w_state_nx = S_IDLE;
        end else if (i_bd_tick) begin
          w_tick_nx = r_tick_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_tick_nx  = '0;
        w_bit_nx   = '0;
      end
    endcase
  end

  // Line level is decoded from the next state so o_tx is a clean register output
  always_comb begin
    w_tx_nx = 1'b1;
    case (w_state_nx)
      S_START:  w_tx_nx = 1'b0;
      S_DATA:   w_tx_nx = w_shift_nx[0];
      S_PARITY: w_tx_nx = w_parity_nx;
      default:  w_tx_nx = 1'b1;
    endcase
  end

  assign w_busy_nx = (w_state_nx != S_IDLE);

  assign o_tx      = r_tx;
  assign o_tx_busy = r_busy;
  assign o_tx_done = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: stimulus queues expected frames, per-DUT line monitors decode and compare.
module tb_uart_transmitter;

  logic        clk = 1'b0;
  logic        r_rst_n;
  logic        r_tick;
  logic        r_tick_en;
  logic [3:0]  r_start;
  logic [15:0] r_data;
  logic [3:0]  w_tx;
  logic [3:0]  w_busy;
  logic [3:0]  w_done;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    int          dut;
    logic [15:0] data;
    logic        par;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  // dut0: defaults, dut1/dut2: 8 bits with even/odd parity, dut3: two stop bits
  uart_transmitter u_dut0 (
    .i_clk(clk), .i_reset(r_rst_n), .i_bd_tick(r_tick), .i_tx_start(r_start[0]),
    .i_data(r_data[9:0]), .o_tx(w_tx[0]), .o_tx_busy(w_busy[0]), .o_tx_done(w_done[0]));

  uart_transmitter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .i_clk(clk), .i_reset(r_rst_n), .i_bd_tick(r_tick), .i_tx_start(r_start[1]),
    .i_data(r_data[7:0]), .o_tx(w_tx[1]), .o_tx_busy(w_busy[1]), .o_tx_done(w_done[1]));

  uart_transmitter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .i_clk(clk), .i_reset(r_rst_n), .i_bd_tick(r_tick), .i_tx_start(r_start[2]),
    .i_data(r_data[7:0]), .o_tx(w_tx[2]), .o_tx_busy(w_busy[2]), .o_tx_done(w_done[2]));

  uart_transmitter #(.STP_BITS_TICKS(32)) u_dut3 (
    .i_clk(clk), .i_reset(r_rst_n), .i_bd_tick(r_tick), .i_tx_start(r_start[3]),
    .i_data(r_data[9:0]), .o_tx(w_tx[3]), .o_tx_busy(w_busy[3]), .o_tx_done(w_done[3]));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // One tick every 4 clocks unless paused
  initial begin
    r_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      r_tick = r_tick_en;
      @(negedge clk);
      r_tick = 1'b0;
    end
  end

  // Line decoder: counts ticks since frame start and records one level per 16-tick slot
  task automatic mon(input int k, input int nb, input int pe, input int stp);
    bit          in_f = 1'b0;
    bit          t;
    bit          bad;
    int          tc = 0;
    int          seg;
    int          nseg = 1 + nb + pe;
    int          tot  = 16 * (1 + nb + pe) + stp;
    logic [31:0] seen;
    logic [31:0] val;
    logic [15:0] got;
    exp_t        e;
    forever begin
      @(posedge clk);
      t = r_tick;
      @(negedge clk);
      if (!r_rst_n) begin
        in_f = 1'b0;
      end else if (in_f) begin
        if (t) tc++;
        if (w_done[k]) begin
          in_f = 1'b0;
          chk($sformatf("len_ticks_dut%0d", k), 32'(tc), 32'(tot));
          chk($sformatf("done_state_dut%0d(busy,tx)", k), {30'd0, w_busy[k], w_tx[k]}, 32'h1);
          chk($sformatf("framing_dut%0d(glitch,start,stop)", k),
              {29'd0, bad, val[0], val[nseg]}, 32'h1);
          if (q.size() == 0) begin
            chk($sformatf("unexpected_frame_dut%0d", k), 32'd1, 32'd0);
          end else begin
            e   = q.pop_front();
            got = '0;
            for (int i = 0; i < nb; i++) got[i] = val[i+1];
            chk("frame_dut_id", 32'(k), 32'(e.dut));
            chk($sformatf("data_dut%0d", k), 32'(got), 32'(e.data));
            if (pe != 0) chk($sformatf("parity_dut%0d", k), 32'(val[nb+1]), 32'(e.par));
          end
        end else if (!w_busy[k]) begin
          in_f = 1'b0;
          chk($sformatf("busy_dropped_dut%0d", k), 32'd0, 32'd1);
        end else begin
          seg = (tc < 16 * nseg) ? tc / 16 : nseg;
          if (!seen[seg]) begin
            seen[seg] = 1'b1;
            val[seg]  = w_tx[k];
          end else if (val[seg] != w_tx[k]) begin
            bad = 1'b1;
          end
        end
      end else begin
        if (w_done[k]) chk($sformatf("spurious_done_dut%0d", k), 32'd1, 32'd0);
        if (w_busy[k]) begin
          in_f = 1'b1;
          tc   = 0;
          bad  = 1'b0;
          seen = 32'd1;
          val  = {31'd0, w_tx[k]};
        end
      end
    end
  endtask

  task automatic send(input int k, input logic [15:0] d, input logic par, input bit expect_it);
    @(negedge clk);
    r_data     = d;
    r_start[k] = 1'b1;
    if (expect_it) q.push_back('{dut: k, data: d, par: par});
    @(negedge clk);
    r_start[k] = 1'b0;
  endtask

  // Returns on the negedge where o_tx_done is seen, or flags a timeout
  task automatic wait_done(input int k);
    bit hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk);
      if (w_done[k]) hit = 1'b1;
    end
    if (!hit) chk($sformatf("timeout_done_dut%0d", k), 32'd0, 32'd1);
  endtask

  initial begin
    r_rst_n   = 1'b0;
    r_tick_en = 1'b1;
    r_start   = '0;
    r_data    = '0;
    fork
      mon(0, 10, 0, 16);
      mon(1, 8, 1, 16);
      mon(2, 8, 1, 16);
      mon(3, 10, 0, 32);
    join_none

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_tx_dut%0d", k), 32'(w_tx[k]), 32'd1);
      chk($sformatf("reset_busy_dut%0d", k), 32'(w_busy[k]), 32'd0);
      chk($sformatf("reset_done_dut%0d", k), 32'(w_done[k]), 32'd0);
    end
    r_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame and loopback words
    send(0, 16'h2A5, 1'b0, 1'b1);
    wait_done(0);
    send(0, 16'h000, 1'b0, 1'b1);
    wait_done(0);
    send(0, 16'h3FF, 1'b0, 1'b1);
    wait_done(0);

    // Ticks paused mid-frame: the line must hold and the frame stays intact
    send(0, 16'h155, 1'b0, 1'b1);
    repeat (150) @(negedge clk);
    r_tick_en = 1'b0;
    repeat (60) @(negedge clk);
    chk("freeze_busy", 32'(w_busy[0]), 32'd1);
    r_tick_en = 1'b1;
    wait_done(0);

    // Parity: 0x07 has three ones -> even parity 1, odd parity 0
    send(1, 16'h07, 1'b1, 1'b1);
    wait_done(1);
    send(2, 16'h07, 1'b0, 1'b1);
    wait_done(2);

    // Start ignored mid-frame, then held through done for a back-to-back frame
    send(0, 16'h001, 1'b0, 1'b1);
    repeat (200) @(negedge clk);
    r_data     = 16'h3FF;
    r_start[0] = 1'b1;
    @(negedge clk);
    r_start[0] = 1'b0;
    @(negedge clk);
    r_data     = 16'h0F0;
    r_start[0] = 1'b1;
    q.push_back('{dut: 0, data: 16'h0F0, par: 1'b0});
    wait_done(0);
    chk("b2b_gap_tx", 32'(w_tx[0]), 32'd1);
    chk("b2b_gap_busy", 32'(w_busy[0]), 32'd0);
    @(negedge clk);
    chk("b2b_start_tx", 32'(w_tx[0]), 32'd0);
    chk("b2b_start_busy", 32'(w_busy[0]), 32'd1);
    r_start[0] = 1'b0;
    wait_done(0);

    // Asynchronous reset during data bit 4
    send(0, 16'h2A5, 1'b0, 1'b0);
    repeat (350) @(negedge clk);
    #1 r_rst_n = 1'b0;
    #1;
    chk("async_reset_tx", 32'(w_tx[0]), 32'd1);
    chk("async_reset_busy", 32'(w_busy[0]), 32'd0);
    chk("async_reset_done", 32'(w_done[0]), 32'd0);
    repeat (3) @(negedge clk);
    chk("reset_hold_done", 32'(w_done[0]), 32'd0);
    r_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 16'h2A5, 1'b0, 1'b1);
    wait_done(0);

    // Two stop bits
    send(3, 16'h2A5, 1'b0, 1'b1);
    wait_done(3);

    repeat (10) @(negedge clk);
    chk("frames_outstanding", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
